mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter in front of a single-port always-accepting memory
//
// Purpose: grants one of two requesters per cycle onto a single memory port.
// m0 has priority, but m1 is guaranteed a grant after STARVE_LIMIT consecutive
// cycles in which it was waiting and lost to m0. Read data returns one cycle
// after acceptance and is routed back to the requester that issued the read.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mX_valid/write/wmask/wdata/addr requester X command (X = 0, 1)
//   mX_ready                       requester X accepted this cycle
//   mX_rvalid/rdata                read response for requester X
//   mem_valid/write/wmask/wdata/addr request to the memory (always accepted)
//   mem_rdata                      memory read data, one cycle after a read

module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid,
    input  logic                  m0_write,
    input  logic [3:0]            m0_wmask,
    input  logic [31:0]           m0_wdata,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_valid,
    input  logic                  m1_write,
    input  logic [3:0]            m1_wmask,
    input  logic [31:0]           m1_wdata,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic                  m1_ready,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       q_rd;
    logic       q_owner;
    logic       limit_hit;
    logic       g0;
    logic       g1;

    // A zero limit means m1 always wins contention; handled separately so the
    // comparison is never made against a constant zero.
    generate
        if (STARVE_LIMIT == 0) begin : g_no_limit
            assign limit_hit = 1'b1;
        end else begin : g_limit
            assign limit_hit = (starve_cnt >= LIMIT);
        end
    endgenerate

    // Grants are suppressed while in reset so nothing reaches the memory.
    always_comb begin
        g1 = 1'b0;
        g0 = 1'b0;
        if (!rst) begin
            g1 = m1_valid & (~m0_valid | limit_hit);
            g0 = m0_valid & ~g1;
        end
    end

    assign m0_ready = g0;
    assign m1_ready = g1;

    always_comb begin
        mem_valid = 1'b0;
        mem_write = 1'b0;
        mem_wmask = 4'h0;
        mem_wdata = 32'h0;
        mem_addr  = '0;
        if (g1) begin
            mem_valid = 1'b1;
            mem_write = m1_write;
            mem_wmask = m1_wmask;
            mem_wdata = m1_wdata;
            mem_addr  = m1_addr;
        end else if (g0) begin
            mem_valid = 1'b1;
            mem_write = m0_write;
            mem_wmask = m0_wmask;
            mem_wdata = m0_wdata;
            mem_addr  = m0_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 8'd0;
            q_rd       <= 1'b0;
            q_owner    <= 1'b0;
        end else begin
            q_rd    <= (g0 & ~m0_write) | (g1 & ~m1_write);
            q_owner <= g1;
            // m1 waiting without a grant implies m0 took the cycle.
            if (g1 || !m1_valid) begin
                starve_cnt <= 8'd0;
            end else if (g0 && !limit_hit) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    assign m0_rvalid = q_rd & ~q_owner;
    assign m1_rvalid = q_rd & q_owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule
